// File: rtl/cdc_c2g_capture.sv
// cdc_c2g_capture: synchronise the count-domain detect level into g_clk, turn each
// assertion into one event, and queue the captured diff/diff-count in a FWFT FIFO.
`timescale 1ns/1ps
module cdc_c2g_capture #(
    parameter int DATASIZE  = 16,
    parameter int COUNTSIZE = 32,
    parameter int FIFO_AW   = 4
) (
    input  logic                   g_clk,
    input  logic                   g_rst,
    input  logic                   c_detect_c2g,
    input  logic [DATASIZE-1:0]    c_diff_c2g,
    input  logic [2*COUNTSIZE-1:0] c_diff_count_c2g,
    input  logic                   g_rd_en,
    output logic                   g_valid,
    output logic [DATASIZE-1:0]    g_diff,
    output logic [2*COUNTSIZE-1:0] g_diff_count,
    output logic [FIFO_AW:0]       g_fifo_count,
    output logic                   g_overflow,
    output logic [31:0]            g_event_cnt,
    output logic [15:0]            g_drop_cnt
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam int W     = DATASIZE + 2*COUNTSIZE;
    logic                 sync1_q, sync2_q, sync3_q, armed_q, armed_d, overflow_q, overflow_d;
    logic [1:0]           warm_q;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
    logic [31:0]          ev_cnt_q, ev_cnt_d;
    logic [15:0]          drop_q, drop_d;
    logic [W-1:0]         mem_q [DEPTH];
    logic                 ev, full, rd, wr, drop;
    assign ev   = sync2_q & ~sync3_q & armed_q;
    assign full = cnt_q == (FIFO_AW+1)'(DEPTH);
    assign rd   = g_rd_en & g_valid;
    assign wr   = ev & (~full | g_rd_en);
    assign drop = ev & full & ~g_rd_en;
    // sync2 only holds a real sample two edges after reset; arming on the reset
    // value would let a detect already high at reset release create an event
    always_comb begin
        armed_d    = armed_q | (warm_q[1] & ~sync2_q);
        wr_ptr_d   = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = (wr & ~rd) ? cnt_q + 1'b1 : (rd & ~wr) ? cnt_q - 1'b1 : cnt_q;
        ev_cnt_d   = ev ? ev_cnt_q + 1'b1 : ev_cnt_q;
        drop_d     = (drop & ~&drop_q) ? drop_q + 1'b1 : drop_q;
        overflow_d = overflow_q | drop;
    end
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            warm_q     <= '0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ev_cnt_q   <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= c_detect_c2g;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            warm_q     <= {warm_q[0], 1'b1};
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ev_cnt_q   <= ev_cnt_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end
    // data buses are quasi-static when ev fires, so they are sampled unsynchronised
    always_ff @(posedge g_clk) begin
        if (wr) mem_q[wr_ptr_q] <= {c_diff_c2g, c_diff_count_c2g};
    end
    assign {g_diff, g_diff_count} = mem_q[rd_ptr_q];
    assign g_valid      = cnt_q != '0;
    assign g_fifo_count = cnt_q;
    assign g_overflow   = overflow_q;
    assign g_event_cnt  = ev_cnt_q;
    assign g_drop_cnt   = drop_q;
endmodule

// File: tb/tb_cdc_c2g_capture.sv
// tb_cdc_c2g_capture: scenario tasks against a queue scoreboard of expected FIFO entries.
`timescale 1ns/1ps
module tb_cdc_c2g_capture;
    logic        g_clk = 1'b0, g_rst = 1'b1, c_detect_c2g = 1'b0, g_rd_en = 1'b0;
    logic [15:0] c_diff_c2g = '0, g_diff;
    logic [63:0] c_diff_count_c2g = '0, g_diff_count;
    logic        g_valid, g_overflow;
    logic [4:0]  g_fifo_count;
    logic [31:0] g_event_cnt;
    logic [15:0] g_drop_cnt;
    logic [79:0] q[$];
    int          checks = 0, failures = 0, m_ev = 0, m_drop = 0;

    cdc_c2g_capture dut (
        .g_clk(g_clk), .g_rst(g_rst), .c_detect_c2g(c_detect_c2g), .c_diff_c2g(c_diff_c2g),
        .c_diff_count_c2g(c_diff_count_c2g), .g_rd_en(g_rd_en), .g_valid(g_valid),
        .g_diff(g_diff), .g_diff_count(g_diff_count), .g_fifo_count(g_fifo_count),
        .g_overflow(g_overflow), .g_event_cnt(g_event_cnt), .g_drop_cnt(g_drop_cnt)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(posedge g_clk);
        #3 g_rst = 1'b1;
        q.delete();
        m_ev = 0;
        m_drop = 0;
        #10 g_rst = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
    endtask

    // one upstream pulse: detect high ~15 ns, data held until after the capture edge
    task automatic send(input logic [15:0] d, input logic [63:0] c, input bit rd_ev);
        @(posedge g_clk);
        #2 c_detect_c2g = 1'b1;
        c_diff_c2g = d;
        c_diff_count_c2g = c;
        @(posedge g_clk);
        #7 c_detect_c2g = 1'b0;
        @(posedge g_clk);
        #1;
        if (rd_ev) begin
            checks++;
            if (q.size() == 0 || {g_valid, g_diff, g_diff_count} !== {1'b1, q[0]}) begin
                failures++;
                $display("FAIL ev_read_head got v=%b %h_%h exp %h", g_valid, g_diff, g_diff_count,
                         q.size() ? q[0] : 80'h0);
            end
            g_rd_en = 1'b1;
        end
        @(posedge g_clk);
        #1 g_rd_en = 1'b0;
        m_ev++;
        if (q.size() == 16 && !rd_ev) m_drop++;
        else begin
            if (rd_ev && q.size() > 0) void'(q.pop_front());
            q.push_back({d, c});
        end
        c_diff_c2g = 16'($urandom);
        c_diff_count_c2g = {$urandom, $urandom};
    endtask

    task automatic pop_check(input string tag);
        checks++;
        if (q.size() == 0 || {g_valid, g_diff, g_diff_count} !== {1'b1, q[0]}) begin
            failures++;
            $display("FAIL %s head got v=%b %h_%h exp %h", tag, g_valid, g_diff, g_diff_count,
                     q.size() ? q[0] : 80'h0);
        end
        g_rd_en = 1'b1;
        @(posedge g_clk);
        #1 g_rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        checks++;
        if (g_fifo_count !== 5'(q.size())) begin
            failures++;
            $display("FAIL %s count got %0d exp %0d", tag, g_fifo_count, q.size());
        end
    endtask

    task automatic check_stats(input string tag, input logic ovf);
        checks++;
        if ({g_event_cnt, g_drop_cnt, g_overflow, g_fifo_count} !==
            {32'(m_ev), 16'(m_drop), ovf, 5'(q.size())}) begin
            failures++;
            $display("FAIL %s stats got ev=%0d drop=%0d ovf=%b cnt=%0d exp ev=%0d drop=%0d ovf=%b cnt=%0d",
                     tag, g_event_cnt, g_drop_cnt, g_overflow, g_fifo_count, m_ev, m_drop, ovf, q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({g_valid, g_fifo_count, g_overflow, g_event_cnt, g_drop_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_values got v=%b cnt=%0d ovf=%b ev=%0d drop=%0d exp all 0",
                     g_valid, g_fifo_count, g_overflow, g_event_cnt, g_drop_cnt);
        end
        #20 g_rst = 1'b0;
        repeat (3) @(posedge g_clk);
        #1 check_stats("after_reset", 1'b0);
    endtask

    task automatic test_single();
        do_reset();
        @(posedge g_clk);
        #2 c_detect_c2g = 1'b1;
        c_diff_c2g = 16'h1234;
        c_diff_count_c2g = 64'h0000_0001_0000_0002;
        @(posedge g_clk);
        #7 c_detect_c2g = 1'b0;
        @(posedge g_clk);
        #1 checks++;
        if (g_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got %b exp 0", g_valid);
        end
        @(posedge g_clk);
        #1 checks++;
        if (g_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_valid_latency got %b exp 1", g_valid);
        end
        c_diff_c2g = 16'hFFFF;
        c_diff_count_c2g = '1;
        m_ev = 1;
        q.push_back({16'h1234, 64'h0000_0001_0000_0002});
        check_stats("single", 1'b0);
        pop_check("single");
        checks++;
        if (g_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_empty_valid got %b exp 0", g_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 20; i++) send(16'(i + 16'h100), {32'(i), 32'hA5A5_0000 + 32'(i)}, 1'b0);
        check_stats("back_to_back", 1'b1);
    endtask

    task automatic test_full_read();
        send(16'hBEEF, 64'hCAFE_F00D_1234_5678, 1'b1);
        check_stats("full_read", 1'b1);
        for (int i = 0; i < 16; i++) pop_check("full_drain");
        checks++;
        if (g_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_drain_valid got %b exp 0", g_valid);
        end
    endtask

    task automatic test_reset_detect_high();
        do_reset();
        @(posedge g_clk);
        #2 c_detect_c2g = 1'b1;
        c_diff_c2g = 16'hDEAD;
        #20 g_rst = 1'b1;
        q.delete();
        m_ev = 0;
        m_drop = 0;
        #13 g_rst = 1'b0;
        repeat (4) @(posedge g_clk);
        #2 c_detect_c2g = 1'b0;
        repeat (4) @(posedge g_clk);
        #1 check_stats("reset_high", 1'b0);
        send(16'h5555, 64'h1111_2222_3333_4444, 1'b0);
        check_stats("reset_high_next", 1'b0);
        pop_check("reset_high_next");
    endtask

    task automatic test_read_empty();
        do_reset();
        g_rd_en = 1'b1;
        repeat (10) @(posedge g_clk);
        #1 g_rd_en = 1'b0;
        check_stats("read_empty", 1'b0);
        send(16'h0A0B, 64'h0102_0304_0506_0708, 1'b0);
        pop_check("read_empty_next");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(16'(16'h7000 + i), {32'(i * 7), 32'(~i)}, 1'b0);
            pop_check("wrap");
        end
        check_stats("wrap", 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_read();
        test_reset_detect_high();
        test_read_empty();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
